// File: rtl/sequencer_pkg.sv
// Shared types and constants for the host-side run sequencer.
// Widths match the data-memory read port.
package sequencer_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      READ,
      DRAIN,
      FINISH
   } seq_state_t;

endpackage

// File: rtl/result_reader.sv
// Result read-back engine: issues RESULT_LEN sequential (wrapping) reads,
// then returns each byte one cycle later together with its address.
module result_reader
   import sequencer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESULT_BASE = 8'd64,
   parameter int                RESULT_LEN  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_start,
   output logic              rd_last,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              res_valid,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DATA_W-1:0] res_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RESULT_LEN - 1);

   logic              issuing_q, issuing_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              res_valid_q, res_valid_d;
   logic [ADDR_W-1:0] res_addr_q, res_addr_d;

   always_comb begin
      issuing_d   = issuing_q;
      idx_d       = idx_q;
      rd_last     = issuing_q && (idx_q == LAST_IDX);
      mem_rd_en   = issuing_q;
      // The 8-bit add wraps addresses past 255 back to 0.
      mem_addr    = issuing_q ? (RESULT_BASE + idx_q) : '0;
      res_valid_d = issuing_q;
      res_addr_d  = mem_addr;
      res_data    = res_valid_q ? mem_rd_data : '0;

      if (rd_start) begin
         issuing_d = 1'b1;
         idx_d     = '0;
      end else if (issuing_q) begin
         idx_d = idx_q + 1'b1;
         if (rd_last) begin
            issuing_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         issuing_q   <= 1'b0;
         idx_q       <= '0;
         res_valid_q <= 1'b0;
         res_addr_q  <= '0;
      end else begin
         issuing_q   <= issuing_d;
         idx_q       <= idx_d;
         res_valid_q <= res_valid_d;
         res_addr_q  <= res_addr_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_addr  = res_addr_q;

endmodule

// File: rtl/run_sequencer.sv
// Host-side run controller: pulses start into the core, times the run until
// done (or timeout), then reads the result block back out of data memory.
module run_sequencer
   import sequencer_pkg::*;
#(
   parameter int                START_CYCLES = 2,
   parameter int                TIMEOUT      = 4096,
   parameter logic [ADDR_W-1:0] RESULT_BASE  = 8'd64,
   parameter int                RESULT_LEN   = 8,
   parameter int                CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   output logic              busy,
   output logic              dut_start,
   input  logic              dut_done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              res_valid,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DATA_W-1:0] res_data,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              timed_out,
   output logic              finished
);

   localparam int              SC_W       = $clog2(START_CYCLES + 1);
   localparam int              CMP_W      = CNT_W + 1;
   localparam logic [SC_W-1:0] START_LOAD = SC_W'(START_CYCLES);
   localparam logic [CMP_W-1:0] TIMEOUT_C = CMP_W'(TIMEOUT);

   seq_state_t       state_q, state_d;
   logic [SC_W-1:0]  start_cnt_q, start_cnt_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             timed_out_q, timed_out_d;
   logic [CNT_W-1:0] count_inc;
   logic             rd_start;
   logic             rd_last;

   always_comb begin
      state_d       = state_q;
      start_cnt_d   = start_cnt_q;
      cycle_count_d = cycle_count_q;
      timed_out_d   = timed_out_q;
      rd_start      = 1'b0;
      count_inc     = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;

      case (state_q)
         IDLE: begin
            start_cnt_d = START_LOAD;
            if (go) begin
               state_d       = START;
               cycle_count_d = '0;
               timed_out_d   = 1'b0;
            end
         end
         START: begin
            start_cnt_d = start_cnt_q - 1'b1;
            if (start_cnt_q == SC_W'(1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Done is checked before the timeout so a tie counts as success.
            cycle_count_d = count_inc;
            if (dut_done) begin
               state_d  = READ;
               rd_start = 1'b1;
            end else if ({1'b0, count_inc} >= TIMEOUT_C) begin
               timed_out_d = 1'b1;
               state_d     = FINISH;
            end
         end
         READ: begin
            if (rd_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN:   state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         start_cnt_q   <= '0;
         cycle_count_q <= '0;
         timed_out_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         cycle_count_q <= cycle_count_d;
         timed_out_q   <= timed_out_d;
      end
   end

   result_reader #(
      .RESULT_BASE (RESULT_BASE),
      .RESULT_LEN  (RESULT_LEN)
   ) u_reader (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_start    (rd_start),
      .rd_last     (rd_last),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .res_valid   (res_valid),
      .res_addr    (res_addr),
      .res_data    (res_data)
   );

   assign busy        = (state_q != IDLE);
   assign dut_start   = (state_q == START);
   assign finished    = (state_q == FINISH);
   assign cycle_count = cycle_count_q;
   assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: vector table, random runs against a
// run-level model, and hand-written reset / go-handling / address-wrap sequences.
module tb_run_sequencer;

   localparam int         S_CYC  = 2;
   localparam int         TMO    = 20;
   localparam int         LEN    = 8;
   localparam logic [7:0] BASE   = 8'd64;
   localparam logic [7:0] BASE_W = 8'd252;

   logic        clk;
   logic        reset_n;
   logic        go;
   logic        dut_done = 1'b0;
   logic        busy, dut_start, mem_rd_en, res_valid, timed_out, finished;
   logic [7:0]  mem_addr, res_addr, res_data;
   logic [7:0]  mem_rd_data = 8'h00;
   logic [15:0] cycle_count;

   logic        go_w;
   logic        done_w;
   logic        busy_w, start_w, rd_en_w, valid_w, to_w, fin_w;
   logic [7:0]  addr_w, raddr_w, rdata_w;
   logic [7:0]  rd_data_w = 8'h00;
   logic [15:0] cc_w;

   logic [7:0]  mem [256];

   int checks   = 0;
   int failures = 0;

   int done_delay = 10;
   bit core_stuck = 1'b0;
   int low_cnt    = 0;

   logic [7:0] mon_addr [$];
   logic [7:0] mon_data [$];
   int fin_count = 0;
   int fin_cc    = 0;
   bit fin_to    = 1'b0;
   int fin_busy  = 0;
   int fin_start = 0;
   int busy_run  = 0;
   int start_run = 0;

   logic [7:0] w_addr [$];
   logic [7:0] w_data [$];
   int w_fin = 0;
   int w_cc  = 0;

   int fin_base = 0;
   int res_base = 0;

   typedef struct {
      int delay;
      bit stuck;
      int cc;
      bit to;
      int n;
      int busy_len;
   } vec_t;

   vec_t vecs [6];

   run_sequencer #(
      .START_CYCLES (S_CYC), .TIMEOUT (TMO), .RESULT_BASE (BASE),
      .RESULT_LEN (LEN), .CNT_W (16)
   ) dut (
      .clk (clk), .reset_n (reset_n), .go (go), .busy (busy),
      .dut_start (dut_start), .dut_done (dut_done), .mem_rd_en (mem_rd_en),
      .mem_addr (mem_addr), .mem_rd_data (mem_rd_data), .res_valid (res_valid),
      .res_addr (res_addr), .res_data (res_data), .cycle_count (cycle_count),
      .timed_out (timed_out), .finished (finished)
   );

   run_sequencer #(
      .START_CYCLES (S_CYC), .TIMEOUT (TMO), .RESULT_BASE (BASE_W),
      .RESULT_LEN (LEN), .CNT_W (16)
   ) dut_wrap (
      .clk (clk), .reset_n (reset_n), .go (go_w), .busy (busy_w),
      .dut_start (start_w), .dut_done (done_w), .mem_rd_en (rd_en_w),
      .mem_addr (addr_w), .mem_rd_data (rd_data_w), .res_valid (valid_w),
      .res_addr (raddr_w), .res_data (rdata_w), .cycle_count (cc_w),
      .timed_out (to_w), .finished (fin_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory model: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      if (rd_en_w)   rd_data_w   <= mem[addr_w];
   end

   // Core model: done is cleared while start is high, rises done_delay cycles
   // after start falls (never if done_delay is 0) and then stays high.
   always @(negedge clk) begin
      if (core_stuck) begin
         dut_done = 1'b1;
      end else if (dut_start) begin
         low_cnt  = 0;
         dut_done = 1'b0;
      end else begin
         low_cnt++;
         if (done_delay != 0 && low_cnt >= done_delay) dut_done = 1'b1;
      end
   end

   // Monitor: records returned bytes and a snapshot of the run at each finished pulse.
   always @(negedge clk) begin
      if (busy) busy_run++; else busy_run = 0;
      if (dut_start) start_run++; else if (!busy) start_run = 0;
      if (res_valid) begin
         mon_addr.push_back(res_addr);
         mon_data.push_back(res_data);
      end
      if (finished) begin
         fin_count++;
         fin_cc    = int'(cycle_count);
         fin_to    = timed_out;
         fin_busy  = busy_run;
         fin_start = start_run;
      end
      if (valid_w) begin
         w_addr.push_back(raddr_w);
         w_data.push_back(rdata_w);
      end
      if (fin_w) begin
         w_fin++;
         w_cc = int'(cc_w);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic waitFinish(input int budget);
      int n;
      n = 0;
      while (fin_count == fin_base && n < budget) begin
         tick();
         n++;
      end
      if (fin_count == fin_base) begin
         checks++;
         failures++;
         $display("[TB] FAIL finish_wait: got no finished pulse expected one within %0d cycles",
                  budget);
      end
   endtask

   task automatic applyStimulus(input int delay, input bit stuck, input int gap);
      done_delay = delay;
      core_stuck = stuck;
      repeat (gap) tick();
      fin_base = fin_count;
      res_base = mon_addr.size();
      go = 1'b1;
      tick();
      go = 1'b0;
      waitFinish(200);
   endtask

   // Run-level reference: what one run must report, from its done delay alone.
   function automatic void model_run(input int delay, input bit stuck, output int cc,
                                     output bit to, output int n, output int busy_len);
      int eff;
      eff = stuck ? 1 : delay;
      if (eff == 0 || eff > TMO) begin
         cc = TMO;
         to = 1'b1;
      end else begin
         cc = eff;
         to = 1'b0;
      end
      n        = to ? 0 : LEN;
      busy_len = S_CYC + cc + (to ? 0 : LEN + 1) + 1;
   endfunction

   task automatic checkRun(input int tag, input int exp_cc, input bit exp_to,
                           input int exp_n, input int exp_busy);
      int got_n;
      logic [7:0] ea;
      checkOutput($sformatf("r%0d_fin_pulses", tag), fin_count - fin_base, 1);
      checkOutput($sformatf("r%0d_cycle_count", tag), fin_cc, exp_cc);
      checkOutput($sformatf("r%0d_timed_out", tag), 32'(fin_to), 32'(exp_to));
      checkOutput($sformatf("r%0d_busy_cycles", tag), fin_busy, exp_busy);
      checkOutput($sformatf("r%0d_start_cycles", tag), fin_start, S_CYC);
      got_n = mon_addr.size() - res_base;
      checkOutput($sformatf("r%0d_res_count", tag), got_n, exp_n);
      for (int i = 0; i < exp_n && i < got_n; i++) begin
         ea = BASE + 8'(i);
         checkOutput($sformatf("r%0d_res_addr%0d", tag, i), 32'(mon_addr[res_base + i]), 32'(ea));
         checkOutput($sformatf("r%0d_res_data%0d", tag, i), 32'(mon_data[res_base + i]),
                     32'(mem[ea]));
      end
      tick();
      tick();
      checkOutput($sformatf("r%0d_cc_held", tag), 32'(cycle_count), exp_cc);
      checkOutput($sformatf("r%0d_to_held", tag), 32'(timed_out), 32'(exp_to));
      checkOutput($sformatf("r%0d_fin_single", tag), fin_count - fin_base, 1);
      checkOutput($sformatf("r%0d_idle", tag), 32'(busy), 0);
   endtask

   initial begin
      int d, gap, cc, n, bl, k;
      bit to;
      logic [7:0] ea;

      vecs[0] = '{delay: 10, stuck: 1'b0, cc: 10, to: 1'b0, n: 8, busy_len: 22};
      vecs[1] = '{delay: 1,  stuck: 1'b0, cc: 1,  to: 1'b0, n: 8, busy_len: 13};
      vecs[2] = '{delay: 20, stuck: 1'b0, cc: 20, to: 1'b0, n: 8, busy_len: 32};
      vecs[3] = '{delay: 21, stuck: 1'b0, cc: 20, to: 1'b1, n: 0, busy_len: 23};
      vecs[4] = '{delay: 0,  stuck: 1'b0, cc: 20, to: 1'b1, n: 0, busy_len: 23};
      vecs[5] = '{delay: 3,  stuck: 1'b1, cc: 1,  to: 1'b0, n: 8, busy_len: 13};

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      reset_n = 1'b0;
      go      = 1'b0;
      go_w    = 1'b0;
      done_w  = 1'b1;

      repeat (3) tick();
      checkOutput("reset_flags", {26'd0, busy, dut_start, mem_rd_en, res_valid, timed_out,
                                  finished}, 0);
      checkOutput("reset_mem_addr", 32'(mem_addr), 0);
      checkOutput("reset_res_addr", 32'(res_addr), 0);
      checkOutput("reset_res_data", 32'(res_data), 0);
      checkOutput("reset_cycle_count", 32'(cycle_count), 0);
      reset_n = 1'b1;
      tick();

      $display("[TB] vector table runs");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].delay, vecs[i].stuck, 1);
         core_stuck = 1'b0;
         checkRun(i, vecs[i].cc, vecs[i].to, vecs[i].n, vecs[i].busy_len);
      end

      $display("[TB] randomized runs");
      for (int r = 0; r < 12; r++) begin
         d   = int'($urandom_range(1, 24));
         gap = int'($urandom_range(0, 3));
         model_run(d, 1'b0, cc, to, n, bl);
         applyStimulus(d, 1'b0, gap);
         checkRun(100 + r, cc, to, n, bl);
      end

      $display("[TB] go while busy");
      done_delay = 10;
      fin_base   = fin_count;
      res_base   = mon_addr.size();
      go = 1'b1;
      tick();
      go = 1'b0;
      repeat (6) tick();
      go = 1'b1;
      tick();
      go = 1'b0;
      waitFinish(200);
      checkOutput("gb_cycle_count", fin_cc, 10);
      repeat (30) tick();
      checkOutput("gb_fin_pulses", fin_count - fin_base, 1);
      checkOutput("gb_idle", 32'(busy), 0);

      $display("[TB] go held through finish");
      done_delay = 21;
      fin_base   = fin_count;
      go = 1'b1;
      tick();
      waitFinish(200);
      done_delay = 10;
      checkOutput("gh_timed_out_first", 32'(fin_to), 1);
      checkOutput("gh_cc_first", fin_cc, TMO);
      tick();
      tick();
      checkOutput("gh_restart", 32'(dut_start), 1);
      checkOutput("gh_cc_cleared", 32'(cycle_count), 0);
      checkOutput("gh_to_cleared", 32'(timed_out), 0);
      go       = 1'b0;
      fin_base = fin_count;
      res_base = mon_addr.size();
      waitFinish(200);
      checkOutput("gh_cc_second", fin_cc, 10);
      checkOutput("gh_to_second", 32'(fin_to), 0);
      checkOutput("gh_res_second", mon_addr.size() - res_base, LEN);
      tick();

      $display("[TB] reset during READ");
      done_delay = 5;
      fin_base   = fin_count;
      res_base   = mon_addr.size();
      go = 1'b1;
      tick();
      go = 1'b0;
      k = 0;
      while (mon_addr.size() - res_base < 3 && k < 100) begin
         tick();
         k++;
      end
      checkOutput("rr_pulses_before", mon_addr.size() - res_base, 3);
      reset_n = 1'b0;
      tick();
      checkOutput("rr_flags", {26'd0, busy, dut_start, mem_rd_en, res_valid, timed_out,
                               finished}, 0);
      checkOutput("rr_cycle_count", 32'(cycle_count), 0);
      checkOutput("rr_mem_addr", 32'(mem_addr), 0);
      reset_n = 1'b1;
      repeat (20) tick();
      checkOutput("rr_no_finish", fin_count - fin_base, 0);
      checkOutput("rr_res_stopped", mon_addr.size() - res_base, 3);
      model_run(7, 1'b0, cc, to, n, bl);
      applyStimulus(7, 1'b0, 0);
      checkRun(200, cc, to, n, bl);

      $display("[TB] address wrap");
      k = w_fin;
      go_w = 1'b1;
      tick();
      go_w = 1'b0;
      d = 0;
      while (w_fin == k && d < 100) begin
         tick();
         d++;
      end
      checkOutput("wrap_fin", w_fin - k, 1);
      checkOutput("wrap_cycle_count", w_cc, 1);
      checkOutput("wrap_count", w_addr.size(), LEN);
      for (int i = 0; i < LEN && i < w_addr.size(); i++) begin
         ea = BASE_W + 8'(i);
         checkOutput($sformatf("wrap_addr%0d", i), 32'(w_addr[i]), 32'(ea));
         checkOutput($sformatf("wrap_data%0d", i), 32'(w_data[i]), 32'(mem[ea]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
